// File: rtl/noc_credit_injector.sv
`default_nettype none
// ============================================================================
// Module      : noc_credit_injector
// Description : Client valid/ready flit stream to credit-based router sends,
//               with packet-atomic destination locking and a local flit FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_credit_injector #(
   parameter int DEST_WIDTH        = 4,
   parameter int FLIT_WIDTH        = 256,
   parameter int FLIT_BUFFER_DEPTH = 2,
   parameter int LOCAL_DEPTH       = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [FLIT_WIDTH-1:0]                  in_data,
   input  logic [DEST_WIDTH-1:0]                  in_dest,
   input  logic                                   in_last,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   output logic [FLIT_WIDTH-1:0]                  data_out,
   output logic [DEST_WIDTH-1:0]                  dest_out,
   output logic                                   is_tail_out,
   output logic                                   send_out,
   input  logic                                   credit_in,
   output logic [$clog2(FLIT_BUFFER_DEPTH+1)-1:0] credit_count,
   output logic                                   err_credit_overflow
);

   localparam int c_CREDIT_W = $clog2(FLIT_BUFFER_DEPTH + 1);
   localparam int c_PTR_W    = $clog2(LOCAL_DEPTH);
   localparam int c_ENTRY_W  = FLIT_WIDTH + DEST_WIDTH + 1;
   localparam logic [c_CREDIT_W-1:0] c_MAX_CREDIT = c_CREDIT_W'(FLIT_BUFFER_DEPTH);
   localparam logic [c_CREDIT_W-1:0] c_CREDIT_ONE = c_CREDIT_W'(1);
   localparam logic [c_PTR_W:0]      c_PTR_ONE    = (c_PTR_W + 1)'(1);
   localparam logic [c_PTR_W:0]      c_FULL_XOR   = {1'b1, {c_PTR_W{1'b0}}};

   typedef enum logic [0:0] {
      ST_HEAD = 1'b0,
      ST_BODY = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [DEST_WIDTH-1:0]   r_cur_dest;
   logic [DEST_WIDTH-1:0]   w_push_dest;

   logic [c_ENTRY_W-1:0]    r_mem [LOCAL_DEPTH];
   logic [c_PTR_W:0]        r_wr_ptr;
   logic [c_PTR_W:0]        r_rd_ptr;
   logic [c_ENTRY_W-1:0]    w_head;
   logic                    w_empty;
   logic                    w_full;
   logic                    w_push;
   logic                    w_send;

   logic [c_CREDIT_W-1:0]   r_credit;
   logic [c_CREDIT_W-1:0]   w_credit_next;
   logic                    w_overflow;
   logic                    r_err;

   logic                    r_send;
   logic [FLIT_WIDTH-1:0]   r_data;
   logic [DEST_WIDTH-1:0]   r_dest;
   logic                    r_tail;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_full   = ((r_wr_ptr ^ r_rd_ptr) == c_FULL_XOR);
   assign w_head   = r_mem[r_rd_ptr[c_PTR_W-1:0]];
   assign in_ready = !rst && !w_full;
   assign w_push   = in_valid && in_ready;
   // A credit arriving this cycle may fund this cycle's send.
   assign w_send   = !w_empty && ((r_credit != '0) || credit_in);

   always_comb begin
      w_state_next = r_state;
      w_push_dest  = r_cur_dest;
      if (r_state == ST_HEAD) begin
         w_push_dest = in_dest;
      end
      if (w_push) begin
         case (r_state)
            ST_HEAD: if (!in_last) w_state_next = ST_BODY;
            ST_BODY: if (in_last)  w_state_next = ST_HEAD;
            default: w_state_next = ST_HEAD;
         endcase
      end
   end

   always_comb begin
      w_credit_next = r_credit;
      w_overflow    = 1'b0;
      case ({w_send, credit_in})
         2'b10: w_credit_next = r_credit - c_CREDIT_ONE;
         2'b01: begin
            if (r_credit == c_MAX_CREDIT) begin
               w_overflow = 1'b1;
            end else begin
               w_credit_next = r_credit + c_CREDIT_ONE;
            end
         end
         default: w_credit_next = r_credit;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[c_PTR_W-1:0]] <= {in_data, w_push_dest, in_last};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_HEAD;
         r_cur_dest <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_credit   <= c_MAX_CREDIT;
         r_err      <= 1'b0;
         r_send     <= 1'b0;
         r_data     <= '0;
         r_dest     <= '0;
         r_tail     <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_credit <= w_credit_next;
         r_send   <= w_send;
         if (w_push && (r_state == ST_HEAD)) begin
            r_cur_dest <= in_dest;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_overflow) begin
            r_err <= 1'b1;
         end
         if (w_send) begin
            {r_data, r_dest, r_tail} <= w_head;
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
      end
   end

   assign send_out            = r_send;
   assign data_out            = r_data;
   assign dest_out            = r_dest;
   assign is_tail_out         = r_tail;
   assign credit_count        = r_credit;
   assign err_credit_overflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_credit_injector.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_credit_injector
// Description : Directed and randomized bench for noc_credit_injector against
//               a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_credit_injector;

   localparam int DW  = 4;
   localparam int FW  = 256;
   localparam int FBD = 2;
   localparam int LD  = 4;
   localparam int CW  = $clog2(FBD + 1);

   typedef struct {
      logic [FW-1:0] d;
      logic [DW-1:0] dest;
      logic          last;
   } entry_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [FW-1:0] in_data;
   logic [DW-1:0] in_dest;
   logic          in_last;
   logic          in_valid;
   logic          in_ready;
   logic [FW-1:0] data_out;
   logic [DW-1:0] dest_out;
   logic          is_tail_out;
   logic          send_out;
   logic          credit_in;
   logic [CW-1:0] credit_count;
   logic          err_credit_overflow;

   int checks   = 0;
   int failures = 0;

   // reference model state
   entry_t        m_q[$];
   int            m_credit;
   bit            m_err;
   bit            m_body;
   logic [DW-1:0] m_cur_dest;
   bit            m_send;
   logic [FW-1:0] m_data;
   logic [DW-1:0] m_dest;
   bit            m_tail;
   int            n_acc;
   int            n_sent;

   noc_credit_injector #(
      .DEST_WIDTH(DW), .FLIT_WIDTH(FW),
      .FLIT_BUFFER_DEPTH(FBD), .LOCAL_DEPTH(LD)
   ) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready),
      .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
      .send_out(send_out), .credit_in(credit_in),
      .credit_count(credit_count), .err_credit_overflow(err_credit_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FW-1:0] rand_flit();
      logic [FW-1:0] r;
      for (int i = 0; i < FW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_credit   = FBD;
      m_err      = 0;
      m_body     = 0;
      m_cur_dest = '0;
      m_send     = 0;
      m_data     = '0;
      m_dest     = '0;
      m_tail     = 0;
   endtask

   // One clock: drive, check in_ready, advance model, check registered outputs.
   task automatic step(input logic v, input logic [FW-1:0] d, input logic [DW-1:0] ds,
                       input logic l, input logic cr, output bit acc);
      bit     exp_ready;
      bit     snd;
      entry_t e;
      in_valid  = v;
      in_data   = d;
      in_dest   = ds;
      in_last   = l;
      credit_in = cr;
      #1;
      exp_ready = !rst && (m_q.size() < LD);
      chk("in_ready", FW'(in_ready), FW'(exp_ready));
      acc = v && exp_ready;
      snd = (m_q.size() > 0) && ((m_credit > 0) || cr);
      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
         acc = 0;
      end else begin
         m_send = snd;
         if (snd) begin
            e      = m_q.pop_front();
            m_data = e.d;
            m_dest = e.dest;
            m_tail = e.last;
            n_sent++;
         end
         m_credit = m_credit - int'(snd) + int'(cr);
         if (m_credit > FBD) begin
            m_credit = FBD;
            m_err    = 1;
         end
         if (acc) begin
            if (!m_body) m_cur_dest = ds;
            e.d    = d;
            e.dest = m_cur_dest;
            e.last = l;
            m_q.push_back(e);
            m_body = !l;
            n_acc++;
         end
      end
      chk("send_out", FW'(send_out), FW'(m_send));
      chk("credit_count", FW'(credit_count), FW'(m_credit));
      chk("err_overflow", FW'(err_credit_overflow), FW'(m_err));
      chk("data_out", data_out, m_data);
      chk("dest_out", FW'(dest_out), FW'(m_dest));
      chk("is_tail_out", FW'(is_tail_out), FW'(m_tail));
   endtask

   task automatic idle(input logic cr);
      bit a;
      step(0, '0, '0, 0, cr, a);
   endtask

   task automatic do_reset();
      rst = 1;
      idle(0);
      idle(0);
      rst = 0;
   endtask

   initial begin
      bit            a;
      int            sends;
      int            guard;
      int            remain;
      int            pushed;
      logic [FW-1:0] fd;
      logic [DW-1:0] fdest;
      rst = 1; in_valid = 0; in_data = '0; in_dest = '0; in_last = 0; credit_in = 0;
      n_acc = 0; n_sent = 0;
      model_reset();

      // reset and idle
      do_reset();
      chk("rst_credit", FW'(credit_count), FW'(2));
      chk("rst_send", FW'(send_out), FW'(0));
      chk("rst_err", FW'(err_credit_overflow), FW'(0));
      chk("rst_data", data_out, '0);
      #1;
      chk("rst_ready_after", FW'(in_ready), FW'(1));
      idle(0);

      // single-flit packet
      step(1, rand_flit(), 4'd3, 1, 0, a);
      idle(0);
      chk("single_send", FW'(send_out), FW'(1));
      chk("single_dest", FW'(dest_out), FW'(3));
      chk("single_tail", FW'(is_tail_out), FW'(1));
      chk("single_credit", FW'(credit_count), FW'(1));
      do_reset();

      // 4-flit packet, dest locked at head, credits exhausted
      sends = 0;
      step(1, rand_flit(), 4'd5, 0, 0, a);
      step(1, rand_flit(), 4'd7, 0, 0, a);
      if (send_out) begin sends++; chk("pkt_dest", FW'(dest_out), FW'(5)); end
      step(1, rand_flit(), 4'd0, 0, 0, a);
      if (send_out) begin sends++; chk("pkt_dest", FW'(dest_out), FW'(5)); end
      step(1, rand_flit(), 4'd9, 1, 0, a);
      if (send_out) begin sends++; chk("pkt_dest", FW'(dest_out), FW'(5)); end
      for (int i = 0; i < 3; i++) begin
         idle(0);
         if (send_out) sends++;
      end
      chk("pkt_sends", FW'(sends), FW'(2));
      chk("pkt_credit0", FW'(credit_count), FW'(0));
      idle(1);
      chk("pkt_credit_send", FW'(send_out), FW'(1));
      chk("pkt_credit_dest", FW'(dest_out), FW'(5));
      idle(0);
      chk("pkt_one_only", FW'(send_out), FW'(0));
      idle(1);
      idle(1);
      do_reset();

      // continuous stream with a credit returned for every send
      for (int i = 0; i < 9; i++) begin
         step(i < 8, rand_flit(), 4'd2, i == 7, send_out, a);
         if (i >= 1) begin
            chk("stream_send", FW'(send_out), FW'(1));
            chk("stream_credit", FW'(credit_count), FW'(1));
         end
      end
      idle(1);

      // credit stall fills the local FIFO, then drain with scoreboard totals
      n_acc = 0; n_sent = 0;
      for (int i = 0; i < 6; i++) step(1, rand_flit(), 4'd4, 0, 0, a);
      #1;
      chk("full_ready", FW'(in_ready), FW'(0));
      pushed = 6; guard = 0;
      fd = rand_flit();
      while (pushed < 10 && guard < 200) begin
         step(1, fd, 4'd4, pushed == 9, (guard > 4) && (m_credit < FBD) && ($urandom_range(0, 1) == 1), a);
         if (a) begin pushed++; fd = rand_flit(); end
         guard++;
      end
      chk("stall_guard", FW'(guard < 200), FW'(1));
      for (int i = 0; i < 40; i++) idle(m_credit < FBD);
      chk("no_loss_dup", FW'(n_sent), FW'(n_acc));
      chk("stall_sent", FW'(n_sent), FW'(10));

      // randomized packets with legal credit returns
      remain = 0; fdest = '0; fd = rand_flit();
      for (int i = 0; i < 300; i++) begin
         if (remain == 0) remain = $urandom_range(1, 4);
         step($urandom_range(0, 3) != 0, fd, 4'($urandom), remain == 1,
              (m_credit < FBD) && ($urandom_range(0, 2) != 0), a);
         if (a) begin remain--; fd = rand_flit(); end
      end
      for (int i = 0; i < 40; i++) idle(m_credit < FBD);
      chk("rand_drained", FW'(n_sent), FW'(n_acc));

      // credit overflow is sticky
      idle(1);
      chk("ovf_err", FW'(err_credit_overflow), FW'(1));
      chk("ovf_credit", FW'(credit_count), FW'(2));
      for (int i = 0; i < 3; i++) idle(0);
      chk("ovf_sticky", FW'(err_credit_overflow), FW'(1));

      // reset mid-packet with flits buffered and no credits
      do_reset();
      chk("ovf_cleared", FW'(err_credit_overflow), FW'(0));
      for (int i = 0; i < 5; i++) step(1, rand_flit(), 4'd6, 0, 0, a);
      chk("mid_credit0", FW'(credit_count), FW'(0));
      rst = 1;
      idle(0);
      rst = 0;
      chk("mid_rst_credit", FW'(credit_count), FW'(2));
      chk("mid_rst_send", FW'(send_out), FW'(0));
      chk("mid_rst_dest", FW'(dest_out), FW'(0));
      step(1, rand_flit(), 4'hA, 1, 0, a);
      chk("mid_no_stale", FW'(send_out), FW'(0));
      idle(0);
      chk("mid_fresh_send", FW'(send_out), FW'(1));
      chk("mid_fresh_dest", FW'(dest_out), FW'(4'hA));
      idle(0);
      chk("mid_empty", FW'(send_out), FW'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
